cpu_ctrl_fsm: RTL
=================

// Module: cpu_ctrl_fsm
// PURPOSE
//  Multi-cycle control stage directly upstream of the CPU ALU. Fetches 32-bit instructions over a req/ack port,
//  reads the register file, drives alu_op/operands, consumes ALU result/zero, and sequences memory and writeback.
//  One instruction in flight; five-state FSM; owns the PC.
// PARAMETERS
//  DW       32  datapath width (ALU operand/result width)
//  AW       16  instruction/data word-address width
//  OPW      6   opcode width (must match ALU alu_op width)
//  RESET_PC 0   PC value after reset
// PORTS
//  clk         in   1    rising-edge clock
//  rst_n       in   1    asynchronous, active-low reset
//  imem_req    out  1    instruction fetch request; held until imem_ack
//  imem_addr   out  AW   fetch address (= pc)
//  imem_ack    in   1    fetch done; imem_rdata valid same cycle
//  imem_rdata  in   32   instruction word
//  rf_ra2      out  5    read addr A = IR[20:16] (rs)
//  rf_ra3      out  5    read addr B = IR[15:11] (rt)
//  rf_rd2      in   DW   read data A (combinational from rf_ra2)
//  rf_rd3      in   DW   read data B
//  alu_op      out  OPW  ALU opcode; 6'b000000 outside EXEC
//  alu_a       out  DW   ALU r2 operand
//  alu_b       out  DW   ALU r3 operand
//  alu_r1      in   DW   ALU result
//  alu_zero    in   1    ALU zero flag
//  dmem_req    out  1    data request; held until dmem_ack
//  dmem_we     out  1    1 = store (SWI), 0 = load (LWI)
//  dmem_addr   out  AW   data address = sext(IR[15:0]) truncated to AW
//  dmem_wdata  out  DW   store data = latched A operand
//  dmem_ack    in   1    data done; dmem_rdata valid same cycle on loads
//  dmem_rdata  in   DW   load data
//  rf_we       out  1    register write strobe, one cycle in WB
//  rf_wa       out  5    write addr = IR[25:21] (rd)
//  rf_wd       out  DW   write data
//  perf_cycles out  32   cycle counter (see CONFIGURATION)
//  perf_instret out 32   retired-instruction counter
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, IR=0, all req/we strobes 0, alu_op=0, operand/result regs 0.
//  States: FETCH -> DECODE -> EXEC -> {MEM ->} WB -> FETCH.
//  FETCH: imem_req=1 from first cycle; on imem_ack latch IR, go DECODE. Ack without req ignored.
//  DECODE (1 cycle): latch A=rf_rd2, B=rf_rd3, imm=sext(IR[15:0]). Opcode 000000 or unknown: pc+=1, -> FETCH (no WB, retired).
//  EXEC (1 cycle): alu_op=IR[31:26]; alu_a/alu_b per class:
//   R-type 010000/010010-010101: a=A, b=B.  I-type 110010-110101: a=A, b=imm.  LI 111001: b=imm.
//   LWI 111011 / SWI 111100: alu_op forced 0, -> MEM.  BEQ 100000: a=A, b=B; alu_zero=1 -> pc=pc+1+imm, else pc+=1; -> FETCH.
//   Others: latch R=alu_r1 at end of cycle, -> WB.
//  MEM: dmem_req=1 held until dmem_ack; LWI latches R=dmem_rdata -> WB; SWI -> pc+=1, FETCH (no WB).
//  WB (1 cycle): rf_we=1, rf_wd=R, rf_wa=IR[25:21]; pc+=1; -> FETCH. rd=0 is written normally (RF decides).
//  PC arithmetic modulo 2^AW (wrap from all-ones to 0, no error). imm truncated to AW for PC/addr.
//  Latency: ALU ops 4 cycles + fetch wait; LWI 5 + both waits; BEQ/NOOP/SWI retire without WB.
//  Reset mid-instruction: abandon instruction, no rf_we/dmem_req glitch; acks arriving after reset ignored until requested.
//  Never imem_req and dmem_req high together.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined: perf_cycles += 1 every cycle out of reset; perf_instret += 1 on each retire
//   (WB, BEQ resolve, NOOP/unknown skip, SWI ack); both wrap at 2^32, reset to 0.
//  Undefined: counters not built; perf_cycles/perf_instret tied to 0.
// STRUCTURE
//  Package cpu_pkg: OPW, opcode localparams (OP_NOOP, OP_MOVE, OP_ADD, OP_SUB, OP_OR, OP_AND, OP_BEQ,
//   OP_ADDI..OP_ANDI, OP_LI, OP_LWI, OP_SWI), state encoding (S_FETCH..S_WB), instruction field bit positions.
//  Sub-module cpu_ctrl_decode: combinational opcode -> {is_rtype, is_itype, is_li, is_mem, is_store, is_branch, is_valid}.
// TESTING
//  ADD: R2=5,R3=7, IR={010010,rd=1,rs=2,rt=3} -> alu_op=010010, a=5,b=7 in EXEC; WB rf_wa=1, rf_wd=12; pc+1.
//  BEQ taken: A=B=9, imm=-3, pc=10 -> alu_zero=1, next fetch addr 8; not taken (A=9,B=8) -> 11; no rf_we.
//  LWI: imm=0x20, dmem_ack after 3-cycle wait, rdata=0xDEAD_BEEF -> dmem_req held 3 cycles, rf_wd=0xDEADBEEF.
//  SWI: A=0x55, imm=4 -> dmem_we=1, dmem_addr=4, dmem_wdata=0x55; no rf_we; retire on ack.
//  Reset in MEM with dmem_req=1 -> req drops async, pc=RESET_PC, next cycle imem_req=1; late dmem_ack ignored.
//  PC wrap (AW=16): NOOP at pc=0xFFFF -> next imem_addr=0x0000; with CTRL_PERF_CNT_EN, instret increments by 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control stage: opcode values, FSM state
// encoding, instruction field positions and the decode class bundle.
// No ports (package).
package cpu_pkg;

    localparam int unsigned OPW = 6;

    // Instruction field bit positions
    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 21;
    localparam int unsigned RS_MSB  = 20;
    localparam int unsigned RS_LSB  = 16;
    localparam int unsigned RT_MSB  = 15;
    localparam int unsigned RT_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OPW-1:0] OP_NOOP = 6'b000000;
    localparam logic [OPW-1:0] OP_MOVE = 6'b010000;
    localparam logic [OPW-1:0] OP_ADD  = 6'b010010;
    localparam logic [OPW-1:0] OP_SUB  = 6'b010011;
    localparam logic [OPW-1:0] OP_OR   = 6'b010100;
    localparam logic [OPW-1:0] OP_AND  = 6'b010101;
    localparam logic [OPW-1:0] OP_BEQ  = 6'b100000;
    localparam logic [OPW-1:0] OP_ADDI = 6'b110010;
    localparam logic [OPW-1:0] OP_SUBI = 6'b110011;
    localparam logic [OPW-1:0] OP_ORI  = 6'b110100;
    localparam logic [OPW-1:0] OP_ANDI = 6'b110101;
    localparam logic [OPW-1:0] OP_LI   = 6'b111001;
    localparam logic [OPW-1:0] OP_LWI  = 6'b111011;
    localparam logic [OPW-1:0] OP_SWI  = 6'b111100;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // is_valid: the opcode executes (NOOP and unknown opcodes are skipped)
    typedef struct packed {
        logic is_rtype;
        logic is_itype;
        logic is_li;
        logic is_mem;
        logic is_store;
        logic is_branch;
        logic is_valid;
    } dec_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode classifier for the control stage.
// Ports: opcode (in, OPW) -> dec (out, dec_t class flags).
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output dec_t           dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_MOVE, OP_ADD, OP_SUB, OP_OR, OP_AND: dec.is_rtype = 1'b1;
            OP_ADDI, OP_SUBI, OP_ORI, OP_ANDI:      dec.is_itype = 1'b1;
            OP_LI:                                  dec.is_li    = 1'b1;
            OP_LWI:                                 dec.is_mem   = 1'b1;
            OP_SWI: begin
                dec.is_mem   = 1'b1;
                dec.is_store = 1'b1;
            end
            OP_BEQ:                                 dec.is_branch = 1'b1;
            OP_NOOP: ;
            default: ;
        endcase
        dec.is_valid = dec.is_rtype | dec.is_itype | dec.is_li | dec.is_mem | dec.is_branch;
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control stage in front of the ALU: fetch over req/ack, register
// read, ALU drive, memory access and writeback, one instruction in flight.
// Ports: clk, rst_n; imem_req/addr/ack/rdata (fetch); rf_ra2/ra3/rd2/rd3 (RF
// read); alu_op/a/b/r1/zero (ALU); dmem_req/we/addr/wdata/ack/rdata (data);
// rf_we/wa/wd (writeback); perf_cycles/perf_instret (counters).
// Build option: define CTRL_PERF_CNT_EN to build the performance counters;
// otherwise both counter outputs are tied to zero.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned   DW       = 32,
    parameter int unsigned   AW       = 16,
    parameter int unsigned   OPW      = cpu_pkg::OPW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           imem_req,
    output logic [AW-1:0]  imem_addr,
    input  logic           imem_ack,
    input  logic [31:0]    imem_rdata,
    output logic [4:0]     rf_ra2,
    output logic [4:0]     rf_ra3,
    input  logic [DW-1:0]  rf_rd2,
    input  logic [DW-1:0]  rf_rd3,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    input  logic [DW-1:0]  alu_r1,
    input  logic           alu_zero,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [AW-1:0]  dmem_addr,
    output logic [DW-1:0]  dmem_wdata,
    input  logic           dmem_ack,
    input  logic [DW-1:0]  dmem_rdata,
    output logic           rf_we,
    output logic [4:0]     rf_wa,
    output logic [DW-1:0]  rf_wd,
    output logic [31:0]    perf_cycles,
    output logic [31:0]    perf_instret
);

    state_t         state, next_state;
    logic [31:0]    ir;
    logic [AW-1:0]  pc;
    logic [DW-1:0]  a_q, imm_q, imm_sext;
    dec_t           dec;
    logic           fetch_done, mem_done, retire;
    logic           imem_req_d, dmem_req_d, dmem_we_d, rf_we_d;
    logic [OPW-1:0] alu_op_d;
    logic [DW-1:0]  alu_a_d, alu_b_d;

    cpu_ctrl_decode u_decode (
        .opcode (ir[OP_MSB:OP_LSB]),
        .dec    (dec)
    );

    assign imm_sext   = {{(DW-16){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
    // Acks only count while the matching request is actually high
    assign fetch_done = (state == S_FETCH) && imem_req && imem_ack;
    assign mem_done   = (state == S_MEM) && dmem_req && dmem_ack;

    assign imem_addr = pc;
    assign rf_ra2    = ir[RS_MSB:RS_LSB];
    assign rf_ra3    = ir[RT_MSB:RT_LSB];
    assign rf_wa     = ir[RD_MSB:RD_LSB];

    // State register plus registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rf_we    <= 1'b0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
        end else begin
            state    <= next_state;
            imem_req <= imem_req_d;
            dmem_req <= dmem_req_d;
            dmem_we  <= dmem_we_d;
            rf_we    <= rf_we_d;
            alu_op   <= alu_op_d;
            alu_a    <= alu_a_d;
            alu_b    <= alu_b_d;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (fetch_done) next_state = S_DECODE;
            S_DECODE: next_state = dec.is_valid ? S_EXEC : S_FETCH;
            S_EXEC: begin
                if (dec.is_mem)         next_state = S_MEM;
                else if (dec.is_branch) next_state = S_FETCH;
                else                    next_state = S_WB;
            end
            S_MEM:    if (mem_done) next_state = dec.is_store ? S_FETCH : S_WB;
            S_WB:     next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // Output logic: values the output registers take for the next state
    always_comb begin
        imem_req_d = (next_state == S_FETCH);
        dmem_req_d = (next_state == S_MEM);
        dmem_we_d  = (next_state == S_MEM) && dec.is_store;
        rf_we_d    = (next_state == S_WB);
        alu_op_d   = '0;
        alu_a_d    = '0;
        alu_b_d    = '0;
        if ((state == S_DECODE) && (next_state == S_EXEC) && !dec.is_mem) begin
            alu_op_d = OPW'(ir[OP_MSB:OP_LSB]);
            if (dec.is_rtype || dec.is_branch) begin
                alu_a_d = rf_rd2;
                alu_b_d = rf_rd3;
            end else if (dec.is_itype) begin
                alu_a_d = rf_rd2;
                alu_b_d = imm_sext;
            end else if (dec.is_li) begin
                alu_b_d = imm_sext;
            end
        end
        retire = ((state == S_DECODE) && !dec.is_valid) ||
                 ((state == S_EXEC) && dec.is_branch) ||
                 (mem_done && dec.is_store) ||
                 (state == S_WB);
    end

    // Datapath registers: IR, operands, memory request payload, result, PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ir         <= '0;
            a_q        <= '0;
            imm_q      <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rf_wd      <= '0;
        end else begin
            if (fetch_done) ir <= imem_rdata;
            if (state == S_DECODE) begin
                a_q   <= rf_rd2;
                imm_q <= imm_sext;
            end
            if ((state == S_EXEC) && dec.is_mem) begin
                dmem_addr  <= imm_q[AW-1:0];
                dmem_wdata <= a_q;
            end
            if ((state == S_EXEC) && !dec.is_mem && !dec.is_branch) rf_wd <= alu_r1;
            if (mem_done && !dec.is_store) rf_wd <= dmem_rdata;
            if ((state == S_EXEC) && dec.is_branch && alu_zero)
                pc <= pc + AW'(1) + imm_q[AW-1:0];
            else if (retire)
                pc <= pc + AW'(1);
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycles_q, instret_q;

    // Free-running cycle and retire counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q  <= '0;
            instret_q <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    assign perf_cycles  = cycles_q;
    assign perf_instret = instret_q;
`else
    assign perf_cycles  = '0;
    assign perf_instret = '0;
`endif

endmodule
